// File: rtl/alu_signature_analyzer.sv
// Multiple-input signature register (MISR) that compresses CYCLES valid ALU results
// and compares the final signature against a golden value.
module alu_signature_analyzer #(
    parameter int             N      = 4,
    parameter int             CYCLES = 10,
    parameter logic [N-1:0]   POLY   = 4'b0011,
    parameter logic [N-1:0]   SEED   = '0,
    parameter logic [N-1:0]   GOLDEN = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         din_valid,
    input  logic [N-1:0] din,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N-1:0] sig,
    output logic [7:0]   count
);

    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

    state_t       state;
    logic [N-1:0] next_sig;
    logic         last;

    // Shift left, fold the dropped MSB back through the taps, then absorb din.
    assign next_sig = {sig[N-2:0], 1'b0} ^ (sig[N-1] ? POLY : '0) ^ din;
    assign last     = (count == 8'(CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            sig   <= SEED;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= CAPTURE;
                        sig   <= SEED;
                        count <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        pass  <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (din_valid) begin
                        sig   <= next_sig;
                        count <= count + 8'd1;
                        if (last) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (next_sig == GOLDEN);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    pass  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_signature_analyzer.sv
// Bench for alu_signature_analyzer: a 3-sample instance for directed cases and a
// 10-sample instance for random streams, both checked against a polynomial model.
module tb_alu_signature_analyzer;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       start;
    logic             din_valid;
    logic [3:0]       din;
    logic [1:0]       busy_a, done_a, pass_a;
    logic [1:0][3:0]  sig_a;
    logic [1:0][7:0]  cnt_a;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: phase 0 idle, 1 capturing, 2 finished.
    int          ph[2];
    logic [3:0]  ms[2];
    int          mc[2];
    bit          mp[2];
    int          cyc_of[2];
    logic [3:0]  gold_of[2];

    always #5 clk = ~clk;

    alu_signature_analyzer #(.N(4), .CYCLES(3), .POLY(4'b0011), .SEED(4'b0000), .GOLDEN(4'b0011)) dut3 (
        .clk(clk), .rst(rst), .start(start[0]), .din_valid(din_valid), .din(din),
        .busy(busy_a[0]), .done(done_a[0]), .pass(pass_a[0]), .sig(sig_a[0]), .count(cnt_a[0]));

    alu_signature_analyzer #(.N(4), .CYCLES(10), .POLY(4'b0011), .SEED(4'b0000), .GOLDEN(4'b1010)) dut10 (
        .clk(clk), .rst(rst), .start(start[1]), .din_valid(din_valid), .din(din),
        .busy(busy_a[1]), .done(done_a[1]), .pass(pass_a[1]), .sig(sig_a[1]), .count(cnt_a[1]));

    // Signature as polynomial arithmetic over GF(2): s*x mod (x^4+x+1), plus d.
    function automatic logic [3:0] gf_step(input logic [3:0] s, input logic [3:0] d);
        int t;
        t = int'(s) * 2;
        if (t >= 16) t = t ^ 'h13;
        return 4'(t) ^ d;
    endfunction

    function automatic void model_edge(input int k);
        if (!rst) begin
            ph[k] = 0; ms[k] = 4'h0; mc[k] = 0; mp[k] = 0;
        end else if (ph[k] != 1 && start[k]) begin
            ph[k] = 1; ms[k] = 4'h0; mc[k] = 0; mp[k] = 0;
        end else if (ph[k] == 1 && din_valid) begin
            ms[k] = gf_step(ms[k], din);
            mc[k] = mc[k] + 1;
            if (mc[k] == cyc_of[k]) begin
                ph[k] = 2;
                mp[k] = (ms[k] == gold_of[k]);
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("busy[%0d]", k), 8'(busy_a[k]), 8'(ph[k] == 1));
            chk($sformatf("done[%0d]", k), 8'(done_a[k]), 8'(ph[k] == 2));
            chk($sformatf("pass[%0d]", k), 8'(pass_a[k]), 8'(ph[k] == 2 && mp[k]));
            chk($sformatf("sig[%0d]", k),  8'(sig_a[k]),  8'(ms[k]));
            chk($sformatf("count[%0d]", k), cnt_a[k], 8'(mc[k]));
        end
    endtask

    // Model both instances with the inputs present before the edge, then check after it.
    task automatic cyc();
        model_edge(0);
        model_edge(1);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic sample(input logic [3:0] d);
        din = d; din_valid = 1'b1; cyc();
        din_valid = 1'b0;
    endtask

    task automatic go(input int k);
        start[k] = 1'b1; cyc(); start[k] = 1'b0;
    endtask

    initial begin
        cyc_of  = '{3, 10};
        gold_of = '{4'b0011, 4'b1010};
        foreach (ph[k]) begin ph[k] = 0; ms[k] = 0; mc[k] = 0; mp[k] = 0; end
        rst = 1'b0; start = 2'b00; din_valid = 1'b0; din = 4'h0;
        // Reset dominates start and din_valid.
        start = 2'b11; din_valid = 1'b1; din = 4'hF;
        cyc(); cyc();
        start = 2'b00; din_valid = 1'b0;
        rst = 1'b1; cyc();

        // Basic stream; the sample presented with start is not compressed.
        start[0] = 1'b1; din_valid = 1'b1; din = 4'hF; cyc();
        start[0] = 1'b0; din_valid = 1'b0;
        sample(4'd1); chk("sig_after_1", 8'(sig_a[0]), 8'h01);
        sample(4'd2); chk("sig_after_2", 8'(sig_a[0]), 8'h00);
        sample(4'd3);
        chk("final_sig", 8'(sig_a[0]), 8'h03);
        chk("final_pass", 8'(pass_a[0]), 8'h01);
        chk("final_done", 8'(done_a[0]), 8'h01);
        chk("final_count", cnt_a[0], 8'd3);
        // DONE holds while din keeps arriving.
        sample(4'd7); sample(4'd9); cyc();

        // Gaps between samples.
        go(0);
        sample(4'd1); cyc(); cyc();
        sample(4'd2); cyc(); cyc();
        sample(4'd3);
        chk("gap_sig", 8'(sig_a[0]), 8'h03);
        chk("gap_pass", 8'(pass_a[0]), 8'h01);

        // Signature mismatch against golden.
        go(0); sample(4'd1); sample(4'd2); sample(4'd4);
        chk("mismatch_pass", 8'(pass_a[0]), 8'h00);
        chk("mismatch_sig", 8'(sig_a[0]), 8'h04);

        // Feedback through the taps when the MSB shifts out.
        go(0);
        sample(4'd8); chk("fb_sig_8", 8'(sig_a[0]), 8'h08);
        sample(4'd0); chk("fb_sig_0", 8'(sig_a[0]), 8'h03);
        sample(4'd5);

        // Reset in DONE, then reset mid-run, then a clean run.
        rst = 1'b0; cyc(); rst = 1'b1; cyc();
        go(0); sample(4'd1); sample(4'd2);
        rst = 1'b0; cyc(); rst = 1'b1;
        chk("abort_sig", 8'(sig_a[0]), 8'h00);
        chk("abort_count", cnt_a[0], 8'd0);
        chk("abort_busy", 8'(busy_a[0]), 8'h00);
        cyc();
        go(0); sample(4'd1); sample(4'd2); sample(4'd3);
        chk("rerun_pass", 8'(pass_a[0]), 8'h01);

        // Random 10-sample runs with gaps and stray start pulses during capture.
        for (int r = 0; r < 6; r++) begin
            go(r % 2);
            for (int i = 0; i < 40 && ph[r % 2] == 1; i++) begin
                din       = 4'($urandom);
                din_valid = 1'($urandom_range(0, 2) != 0);
                start[r % 2] = 1'($urandom_range(0, 4) == 0);
                cyc();
            end
            start = 2'b00; din_valid = 1'b0;
            chk($sformatf("rand_done_%0d", r), 8'(done_a[r % 2]), 8'h01);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_signature_analyzer.md
ALU_SIGNATURE_ANALYZER -- requirements
Module: alu_signature_analyzer

Interface
REQ-001 SHALL have parameter N, default 4, data width of the captured ALU result.
REQ-002 SHALL have parameter CYCLES, default 10, number of valid samples compressed per run (legal range 1..255).
REQ-003 SHALL have parameter POLY, default 4'b0011 (x^4+x+1), MISR feedback taps, N bits.
REQ-004 SHALL have parameter SEED, default 0, MISR initial value, N bits.
REQ-005 SHALL have parameter GOLDEN, default 0, expected signature, N bits.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-low.
REQ-008 start  input  1  begin a run; sampled on rising edge.
REQ-009 din_valid  input  1  din carries a sample this cycle.
REQ-010 din  input  N  registered ALU result to be compressed.
REQ-011 busy  output  1  high while in CAPTURE.
REQ-012 done  output  1  high while in DONE.
REQ-013 pass  output  1  signature == GOLDEN; meaningful only when done=1, else 0.
REQ-014 sig  output  N  current MISR contents.
REQ-015 count  output  8  valid samples taken in the current run.

Function
REQ-016 SHALL implement a registered FSM with states IDLE, CAPTURE, DONE; all outputs driven from registers.
REQ-017 IDLE: start=1 -> CAPTURE next cycle; sig<=SEED, count<=0 on the same edge.
REQ-018 CAPTURE, din_valid=1: sig<={sig[N-2:0],0} ^ (sig[N-1] ? POLY : 0) ^ din; count<=count+1.
REQ-019 CAPTURE, din_valid=0: sig and count hold; no timeout.
REQ-020 CAPTURE: the edge taking valid sample number CYCLES (count==CYCLES-1, din_valid=1) SHALL update sig and move to DONE.
REQ-021 On entry to DONE, pass SHALL equal (new sig == GOLDEN), registered on the same edge; done=1, busy=0.
REQ-022 DONE: sig, count, pass hold; start=1 -> restart per REQ-017 (done and pass drop next cycle).
REQ-023 start SHALL be ignored while in CAPTURE.
REQ-024 din SHALL be ignored in IDLE and DONE; din_valid never alters sig outside CAPTURE.
REQ-025 start and din_valid high in the same IDLE cycle: only start acts; that sample is not compressed.
REQ-026 Latency: done rises exactly one clock after the edge that samples the CYCLES-th valid input is presented, i.e. it is visible the cycle after the last valid din.
REQ-027 count SHALL never exceed CYCLES; no wrap within a run.

Reset
REQ-028 rst=0 at a rising edge SHALL force IDLE, sig=SEED, count=0, busy=0, done=0, pass=0.
REQ-029 Reset asserted mid-CAPTURE or in DONE SHALL abort the run with no partial result retained.
REQ-030 Reset SHALL dominate start and din_valid on the same edge.

Verification
REQ-031 Defaults with CYCLES=3, GOLDEN=4'b0011: start, then din=1,2,3 valid on consecutive cycles -> sig 0001,0000,0011; done=1, pass=1, count=3.
REQ-032 Feedback: CYCLES=2, din=8 then 0 -> sig 1000 then 0011 (MSB drop with POLY XOR).
REQ-033 Gaps: same stream as REQ-031 with din_valid=0 for two cycles between samples -> identical final sig 0011, busy held throughout gaps.
REQ-034 Mismatch: GOLDEN=4'b0101, stream of REQ-031 -> done=1, pass=0, sig=0011.
REQ-035 Reset mid-run: rst=0 after second sample -> next cycle IDLE, sig=0000, count=0, done=0; new start produces a full clean run.
REQ-036 CYCLES=10 driven by 10 $random samples from the ALU-with-register bench -> done after the 10th valid sample, sig matches a bench-computed MISR model, start during CAPTURE has no effect.
